// File: rtl/regfile_if.sv
// Register-file port bundle: two read ports and one write port.
// The datapath side (decode/write-back) is the master, the register file is the slave.
interface regfile_if #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned NREGS = 32,
  parameter int unsigned ABITS = $clog2(NREGS)
);
  logic [ABITS-1:0] rdReg1;
  logic [ABITS-1:0] rdReg2;
  logic [WIDTH-1:0] rdData1;
  logic [WIDTH-1:0] rdData2;
  logic [ABITS-1:0] wrReg;
  logic [WIDTH-1:0] wrData;
  // Write handshake: wrEn is a valid with no ready; the register file is always
  // ready, so a write is taken on every rising clk where wrEn=1 and reset=1.
  logic             wrEn;

  modport master (
    output rdReg1, rdReg2, wrReg, wrData, wrEn,
    input  rdData1, rdData2
  );

  modport slave (
    input  rdReg1, rdReg2, wrReg, wrData, wrEn,
    output rdData1, rdData2
  );
endinterface

// File: rtl/regfile.sv
// NREGS x WIDTH register file, two combinational read ports with write-through
// bypass, one synchronous write port; entry NREGS-1 is the hardwired zero register.
module regfile #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned NREGS = 32,
  parameter int unsigned ABITS = $clog2(NREGS)
) (
  input  logic      clk,
  input  logic      reset,
  regfile_if.slave  bus
);

  localparam int unsigned XZR = NREGS - 1;

  // Storage exists only for the writable entries; XZR has no flops.
  logic [WIDTH-1:0] mem     [NREGS-1];
  logic [WIDTH-1:0] rd_view [NREGS];
  logic [NREGS-2:0] wr_sel;

  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < NREGS - 1; i++) begin
      wr_sel[i] = bus.wrEn && (bus.wrReg == ABITS'(i));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS - 1; i++) begin
        mem[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREGS - 1; i++) begin
        if (wr_sel[i]) begin
          mem[i] <= bus.wrData;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NREGS - 1; i++) begin
      rd_view[i] = mem[i];
    end
    rd_view[XZR] = '0;
  end

  // Bypass forwards wrData to a port reading the write target this cycle;
  // it is gated by reset and never applies to XZR.
  logic byp1;
  logic byp2;

  always_comb begin
    byp1 = reset && bus.wrEn && (bus.wrReg == bus.rdReg1) && (bus.rdReg1 != ABITS'(XZR));
    byp2 = reset && bus.wrEn && (bus.wrReg == bus.rdReg2) && (bus.rdReg2 != ABITS'(XZR));
  end

  always_comb begin
    bus.rdData1 = byp1 ? bus.wrData : rd_view[bus.rdReg1];
    bus.rdData2 = byp2 ? bus.wrData : rd_view[bus.rdReg2];
  end

endmodule

// File: tb/tb_regfile.sv
// Directed self-checking bench for regfile: reset, write/hold, XZR, bypass,
// full readback and reset-vs-write collisions.
module tb_regfile;
  localparam int unsigned W = 64;
  localparam int unsigned N = 32;
  localparam int unsigned A = 5;

  logic clk;
  logic reset;
  int   errors;
  int   checks;
  logic [W-1:0] exp_q [$];
  logic [W-1:0] e;

  regfile_if #(.WIDTH(W), .NREGS(N)) bus ();

  regfile #(.WIDTH(W), .NREGS(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // drivers
  task automatic drive_wr(input logic [A-1:0] a, input logic [W-1:0] d, input logic en);
    bus.wrReg  = a;
    bus.wrData = d;
    bus.wrEn   = en;
  endtask

  task automatic drive_rd(input logic [A-1:0] a1, input logic [A-1:0] a2);
    bus.rdReg1 = a1;
    bus.rdReg2 = a2;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // scoreboard check
  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b0;
    drive_wr(5'd0, '0, 1'b0);
    drive_rd(5'd0, 5'd1);
    check("rst_rd1_0", bus.rdData1, 64'h0);
    check("rst_rd2_1", bus.rdData2, 64'h0);
    tick();
    reset = 1'b1;
    drive_rd(5'd5, 5'd30);
    check("post_rst_rd1_5", bus.rdData1, 64'h0);
    check("post_rst_rd2_30", bus.rdData2, 64'h0);

    // write 5, then change wrData with wrEn=0
    drive_wr(5'd5, 64'hDEAD_BEEF_0000_0001, 1'b1);
    tick();
    drive_wr(5'd5, 64'h0123_4567_89AB_CDEF, 1'b0);
    drive_rd(5'd5, 5'd6);
    check("wr5_now", bus.rdData1, 64'hDEAD_BEEF_0000_0001);
    check("wr5_neighbour6", bus.rdData2, 64'h0);
    tick();
    check("wr5_later1", bus.rdData1, 64'hDEAD_BEEF_0000_0001);
    tick();
    check("wr5_later2", bus.rdData1, 64'hDEAD_BEEF_0000_0001);

    // write to XZR
    drive_wr(5'd31, {W{1'b1}}, 1'b1);
    drive_rd(5'd31, 5'd31);
    check("xzr_byp_rd1", bus.rdData1, 64'h0);
    check("xzr_byp_rd2", bus.rdData2, 64'h0);
    tick();
    check("xzr_after_rd1", bus.rdData1, 64'h0);
    drive_wr(5'd31, {W{1'b1}}, 1'b0);
    tick();
    check("xzr_later_rd2", bus.rdData2, 64'h0);

    // bypass on entry 7
    drive_wr(5'd7, 64'h1111, 1'b1);
    tick();
    drive_wr(5'd7, 64'h2222, 1'b1);
    drive_rd(5'd7, 5'd7);
    check("byp_pre_rd1", bus.rdData1, 64'h2222);
    check("byp_pre_rd2", bus.rdData2, 64'h2222);
    drive_rd(5'd7, 5'd5);
    check("byp_only_port1", bus.rdData2, 64'hDEAD_BEEF_0000_0001);
    drive_rd(5'd7, 5'd7);
    tick();
    drive_wr(5'd7, 64'h9999, 1'b0);
    drive_rd(5'd7, 5'd7);
    check("byp_post_rd1", bus.rdData1, 64'h2222);
    check("byp_post_rd2", bus.rdData2, 64'h2222);

    // wrEn=0 holds entry 3
    drive_wr(5'd3, 64'h3, 1'b1);
    tick();
    drive_wr(5'd3, 64'hCACA, 1'b0);
    tick();
    drive_rd(5'd3, 5'd3);
    check("hold3_rd1", bus.rdData1, 64'h3);
    check("hold3_rd2", bus.rdData2, 64'h3);

    // fill 0..30 with index, read both ports
    for (int i = 0; i < 31; i++) begin
      drive_wr(A'(i), W'(i), 1'b1);
      tick();
    end
    drive_wr(5'd0, '0, 1'b0);
    for (int i = 0; i < 32; i++) begin
      exp_q.push_back((i == 31) ? 64'h0 : W'(i));
      exp_q.push_back((i == 0) ? 64'h0 : W'(31 - i));
    end
    for (int i = 0; i < 32; i++) begin
      drive_rd(A'(i), A'(31 - i));
      e = exp_q.pop_front();
      check($sformatf("fill_rd1_%0d", i), bus.rdData1, e);
      e = exp_q.pop_front();
      check($sformatf("fill_rd2_%0d", 31 - i), bus.rdData2, e);
    end

    // mid-run async reset
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      drive_rd(A'(i), A'((i + 7) % 32));
      check($sformatf("mid_rst_rd1_%0d", i), bus.rdData1, 64'h0);
      check($sformatf("mid_rst_rd2_%0d", (i + 7) % 32), bus.rdData2, 64'h0);
    end
    drive_wr(5'd9, 64'hFEED, 1'b1);
    drive_rd(5'd9, 5'd9);
    check("rst_wr9_nobyp", bus.rdData1, 64'h0);
    tick();
    check("rst_wr9_edge", bus.rdData1, 64'h0);
    drive_wr(5'd9, 64'hFEED, 1'b0);
    reset = 1'b1;
    drive_rd(5'd9, 5'd9);
    check("rst_wr9_after", bus.rdData2, 64'h0);

    // reset in the same cycle as a write to 2
    drive_wr(5'd2, 64'h5A5A, 1'b1);
    tick();
    drive_wr(5'd2, 64'hABCD, 1'b1);
    reset = 1'b0;
    drive_rd(5'd2, 5'd2);
    check("coll_pre_rd1", bus.rdData1, 64'h0);
    tick();
    reset = 1'b1;
    drive_wr(5'd2, 64'hABCD, 1'b0);
    drive_rd(5'd2, 5'd2);
    check("coll_post_rd1", bus.rdData1, 64'h0);
    drive_wr(5'd2, 64'h5555, 1'b1);
    tick();
    drive_wr(5'd2, 64'h0, 1'b0);
    drive_rd(5'd2, 5'd5);
    check("coll_rewrite_rd1", bus.rdData1, 64'h5555);
    check("coll_other5_rd2", bus.rdData2, 64'h0);

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
